// File: rtl/alu_modos_pkg.sv
// -----------------------------------------------------------------------------
// alu_modos_pkg
// Shared types and constants for the clocked lab ALU front panel.
//   op_e      : the ten operation modes selected by the mode counter
//   state_e   : IDLE / CALC / SHOW
//   FLAG_*    : bit positions of {N,C,Z,V} inside the 4-bit flag vector
//   SEG_*     : active-low seven-segment patterns (bit6=a .. bit0=g)
// -----------------------------------------------------------------------------
package alu_modos_pkg;

  typedef enum logic [3:0] {
    OP_ADD = 4'd0,
    OP_SUB = 4'd1,
    OP_AND = 4'd2,
    OP_OR  = 4'd3,
    OP_XOR = 4'd4,
    OP_SLL = 4'd5,
    OP_SRL = 4'd6,
    OP_SRA = 4'd7,
    OP_MUL = 4'd8,
    OP_NOT = 4'd9
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_SHOW = 2'd2
  } state_e;

  localparam int FLAG_N = 3;
  localparam int FLAG_C = 2;
  localparam int FLAG_Z = 1;
  localparam int FLAG_V = 0;

  localparam int MODE_LAST = 9;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_ONE   = 7'h4F;

endpackage

// File: rtl/alu_modos_sync_if.sv
// -----------------------------------------------------------------------------
// alu_modos_sync_if
// Board-side bundle of the ALU front panel.
//   selector, start : active-low push-buttons (asynchronous to clk)
//   A, B            : N-bit operand switches
//   display1..6     : active-low seven-segment outputs
//   flags           : {N,C,Z,V} flag LEDs
//   valid           : high while a result is being shown
// Modports: master = board/stimulus side, slave = the ALU.
// -----------------------------------------------------------------------------
interface alu_modos_sync_if #(
  parameter int N = 4
);
  logic         selector;
  logic         start;
  logic [N-1:0] A;
  logic [N-1:0] B;
  logic [6:0]   display1;
  logic [6:0]   display2;
  logic [6:0]   display3;
  logic [6:0]   display4;
  logic [6:0]   display5;
  logic [6:0]   display6;
  logic [3:0]   flags;
  logic         valid;

  modport master (
    output selector, start, A, B,
    input  display1, display2, display3, display4, display5, display6,
    input  flags, valid
  );

  modport slave (
    input  selector, start, A, B,
    output display1, display2, display3, display4, display5, display6,
    output flags, valid
  );
endinterface

// File: rtl/btn_debounce.sv
// -----------------------------------------------------------------------------
// btn_debounce
// Conditions one active-low push-button: 2-FF synchroniser, then a counter
// that accepts a new level only after DEBOUNCE_CYCLES consecutive cycles of
// disagreement with the accepted level. A press (accepted 1->0) produces a
// single-cycle pulse; a release produces nothing.
//   clk, reset : clock and asynchronous active-high reset
//   i_btn_n    : raw button, active-low, asynchronous
//   o_press    : one-cycle press pulse
// -----------------------------------------------------------------------------
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 250000
) (
  input  logic clk,
  input  logic reset,
  input  logic i_btn_n,
  output logic o_press
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          r_sync1;
  logic          r_sync2;
  logic          r_level;
  logic          r_press;
  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
      r_level <= 1'b1;
      r_press <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_sync1 <= i_btn_n;
      r_sync2 <= r_sync1;
      r_press <= 1'b0;
      if (r_sync2 != r_level) begin
        // This cycle is the last of the required run: take the new level.
        if (r_cnt == CNT_LAST) begin
          r_level <= r_sync2;
          r_cnt   <= '0;
          r_press <= ~r_sync2;
        end else begin
          r_cnt <= r_cnt + CW'(1);
        end
      end else begin
        r_cnt <= '0;
      end
    end
  end

  assign o_press = r_press;

endmodule

// File: rtl/seg7_hex.sv
// -----------------------------------------------------------------------------
// seg7_hex
// Hex digit to active-low seven-segment decoder with a blank override.
//   i_hex   : 4-bit value to show
//   i_blank : 1 forces all segments off
//   o_seg   : segments, bit6=a .. bit0=g, 0 = lit
// -----------------------------------------------------------------------------
module seg7_hex
  import alu_modos_pkg::*;
(
  input  logic [3:0] i_hex,
  input  logic       i_blank,
  output logic [6:0] o_seg
);

  always_comb begin
    o_seg = SEG_BLANK;
    if (!i_blank) begin
      case (i_hex)
        4'h0: o_seg = 7'h01;
        4'h1: o_seg = 7'h4F;
        4'h2: o_seg = 7'h12;
        4'h3: o_seg = 7'h06;
        4'h4: o_seg = 7'h4C;
        4'h5: o_seg = 7'h24;
        4'h6: o_seg = 7'h20;
        4'h7: o_seg = 7'h0F;
        4'h8: o_seg = 7'h00;
        4'h9: o_seg = 7'h04;
        4'hA: o_seg = 7'h08;
        4'hB: o_seg = 7'h60;
        4'hC: o_seg = 7'h31;
        4'hD: o_seg = 7'h42;
        4'hE: o_seg = 7'h30;
        default: o_seg = 7'h38;
      endcase
    end
  end

endmodule

// File: rtl/alu_modos_sync.sv
// -----------------------------------------------------------------------------
// alu_modos_sync
// Clocked lab ALU front panel. Two debounced buttons step the mode (0..9) and
// trigger a computation; operands are latched on start, the result and
// {N,C,Z,V} flags are registered one cycle later and shown on six active-low
// seven-segment displays.
//   clk, reset : clock and asynchronous active-high reset
//   bus        : alu_modos_sync_if.slave (buttons, operands, displays, flags,
//                valid)
// -----------------------------------------------------------------------------
module alu_modos_sync
  import alu_modos_pkg::*;
#(
  parameter int N               = 4,
  parameter int DEBOUNCE_CYCLES = 250000
) (
  input  logic             clk,
  input  logic             reset,
  alu_modos_sync_if.slave  bus
);

  localparam logic [1:0] S_IDLE = ST_IDLE;
  localparam logic [1:0] S_CALC = ST_CALC;
  localparam logic [1:0] S_SHOW = ST_SHOW;

  localparam logic [N-1:0] SHIFT_LIMIT = N'(N);

  logic w_sel_press;
  logic w_start_press;

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_sel_btn (
    .clk     (clk),
    .reset   (reset),
    .i_btn_n (bus.selector),
    .o_press (w_sel_press)
  );

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_start_btn (
    .clk     (clk),
    .reset   (reset),
    .i_btn_n (bus.start),
    .o_press (w_start_press)
  );

  logic [1:0]   r_state;
  logic [3:0]   r_mode;
  logic [N-1:0] r_a;
  logic [N-1:0] r_b;
  logic [N-1:0] r_result;
  logic [3:0]   r_flags;

  // ---------------- datapath on the latched operands ----------------
  logic [N:0]          w_sum;
  logic [N:0]          w_diff;
  logic [2*N-1:0]      w_prod;
  logic signed [N-1:0] w_sra;
  logic                w_shift_big;
  logic [N-1:0]        w_res;
  logic                w_c;
  logic                w_v;
  logic [3:0]          w_flags;

  assign w_sum       = {1'b0, r_a} + {1'b0, r_b};
  assign w_diff      = {1'b0, r_a} - {1'b0, r_b};   // bit N is the borrow
  assign w_prod      = {{N{1'b0}}, r_a} * {{N{1'b0}}, r_b};
  assign w_sra       = $signed(r_a) >>> r_b;
  assign w_shift_big = (r_b >= SHIFT_LIMIT);

  always_comb begin
    w_res = '0;
    w_c   = 1'b0;
    w_v   = 1'b0;
    case (op_e'(r_mode))
      OP_ADD: begin
        w_res = w_sum[N-1:0];
        w_c   = w_sum[N];
        w_v   = (r_a[N-1] == r_b[N-1]) && (w_sum[N-1] != r_a[N-1]);
      end
      OP_SUB: begin
        w_res = w_diff[N-1:0];
        w_c   = w_diff[N];
        w_v   = (r_a[N-1] != r_b[N-1]) && (w_diff[N-1] != r_a[N-1]);
      end
      OP_AND: w_res = r_a & r_b;
      OP_OR:  w_res = r_a | r_b;
      OP_XOR: w_res = r_a ^ r_b;
      OP_SLL: w_res = w_shift_big ? '0 : (r_a << r_b);
      OP_SRL: w_res = w_shift_big ? '0 : (r_a >> r_b);
      OP_SRA: w_res = w_shift_big ? {N{r_a[N-1]}} : w_sra;
      OP_MUL: begin
        w_res = w_prod[N-1:0];
        w_c   = |w_prod[2*N-1:N];
      end
      OP_NOT: w_res = ~r_a;
      default: w_res = '0;
    endcase

    w_flags         = '0;
    w_flags[FLAG_N] = w_res[N-1];
    w_flags[FLAG_C] = w_c;
    w_flags[FLAG_Z] = (w_res == '0);
    w_flags[FLAG_V] = w_v;
  end

  // ---------------- control FSM and mode counter ----------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_mode   <= 4'd0;
      r_a      <= '0;
      r_b      <= '0;
      r_result <= '0;
      r_flags  <= 4'b0000;
    end else begin
      case (r_state)
        S_IDLE: begin
          // Start has priority over a same-cycle mode step.
          if (w_start_press) begin
            r_a     <= bus.A;
            r_b     <= bus.B;
            r_state <= S_CALC;
          end else if (w_sel_press) begin
            r_mode <= (r_mode == 4'(MODE_LAST)) ? 4'd0 : r_mode + 4'd1;
          end
        end
        S_CALC: begin
          r_result <= w_res;
          r_flags  <= w_flags;
          r_state  <= S_SHOW;
        end
        S_SHOW: begin
          if (w_start_press) begin
            r_a     <= bus.A;
            r_b     <= bus.B;
            r_state <= S_CALC;
          end else if (w_sel_press) begin
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // ---------------- displays ----------------
  logic       w_show;
  logic [7:0] w_res_ext;
  logic [3:0] w_digit [6];
  logic       w_blank [6];
  logic [6:0] w_seg   [6];

  assign w_show    = (r_state == S_SHOW);
  assign w_res_ext = 8'(r_result);

  // Flag displays reuse the decoder: digit "1", blanked when the flag is clear.
  always_comb begin
    w_digit[0] = w_show ? w_res_ext[3:0] : r_mode;
    w_blank[0] = 1'b0;
    w_digit[1] = w_res_ext[7:4];
    w_blank[1] = !(w_show && (N > 4));
    w_digit[2] = 4'h1;
    w_blank[2] = !(w_show && r_flags[FLAG_N]);
    w_digit[3] = 4'h1;
    w_blank[3] = !(w_show && r_flags[FLAG_C]);
    w_digit[4] = 4'h1;
    w_blank[4] = !(w_show && r_flags[FLAG_Z]);
    w_digit[5] = 4'h1;
    w_blank[5] = !(w_show && r_flags[FLAG_V]);
  end

  generate
    for (genvar gi = 0; gi < 6; gi++) begin : g_seg
      seg7_hex u_seg (
        .i_hex   (w_digit[gi]),
        .i_blank (w_blank[gi]),
        .o_seg   (w_seg[gi])
      );
    end
  endgenerate

  assign bus.display1 = w_seg[0];
  assign bus.display2 = w_seg[1];
  assign bus.display3 = w_seg[2];
  assign bus.display4 = w_seg[3];
  assign bus.display5 = w_seg[4];
  assign bus.display6 = w_seg[5];
  assign bus.flags    = r_flags;
  assign bus.valid    = w_show;

endmodule
